// File: rtl/aresetn_seq_pkg.sv
// Shared types and helpers for the aresetn_seq reset sequencer.
package aresetn_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Ceiling log2 with a floor of 1 so every derived vector keeps at least one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((32'sd1 <<< w) < value) begin
      w = w + 32'sd1;
    end
    if (w < 32'sd1) begin
      w = 32'sd1;
    end
    return w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/aresetn_sync.sv
// Plain reset synchroniser: asynchronous assertion, deassertion after SYNC_STAGES aclk edges.
module aresetn_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic aclk,
  input  logic aresetn_in,
  output logic sync_n
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_r;

  // Shift a constant 1 through the chain; any reset edge clears it at once.
  always_ff @(posedge aclk or negedge aresetn_in) begin
    if (!aresetn_in) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_n = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/aresetn_seq.sv
// Reset synchroniser and release sequencer for the aclk domain.
// Optional soft_reset_count output enabled by defining ARESETN_SEQ_SOFT_CNT_EN.
module aresetn_seq
  import aresetn_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int NUM_OUT        = 3,
  parameter int STRETCH_CYCLES = 16,
  parameter int STEP_CYCLES    = 8
) (
  input  logic               aclk,
  input  logic               aresetn_in,
  input  logic               soft_reset,
  output logic [NUM_OUT-1:0] aresetn_out,
  output logic               reset_done,
  output logic               busy
`ifdef ARESETN_SEQ_SOFT_CNT_EN
  ,output logic [15:0]       soft_reset_count
`endif
);

  localparam int CNT_W = clog2_min1(max_int(STRETCH_CYCLES, STEP_CYCLES));
  localparam int IDX_W = clog2_min1(NUM_OUT);
  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LOAD    = CNT_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_OUT - 1);

  logic               sync_n_s;
  logic               soft_req_s;
  state_e             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [IDX_W-1:0]   idx_r;
  logic [NUM_OUT-1:0] aresetn_out_r;
  logic               reset_done_r;
  logic               busy_r;

  aresetn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .aclk       (aclk),
    .aresetn_in (aresetn_in),
    .sync_n     (sync_n_s)
  );

  // Soft requests only count once the synchroniser has let the FSM out of ASSERT.
  assign soft_req_s = soft_reset && (state_r != ASSERT);

  // Sequencer FSM with registered outputs.
  always_ff @(posedge aclk or negedge aresetn_in) begin
    if (!aresetn_in) begin
      state_r       <= ASSERT;
      cnt_r         <= {CNT_W{1'b0}};
      idx_r         <= {IDX_W{1'b0}};
      aresetn_out_r <= {NUM_OUT{1'b0}};
      reset_done_r  <= 1'b0;
      busy_r        <= 1'b1;
    end else if (soft_req_s) begin
      state_r       <= STRETCH;
      cnt_r         <= STRETCH_LOAD;
      idx_r         <= {IDX_W{1'b0}};
      aresetn_out_r <= {NUM_OUT{1'b0}};
      reset_done_r  <= 1'b0;
      busy_r        <= 1'b1;
    end else begin
      case (state_r)
        ASSERT: begin
          if (sync_n_s) begin
            state_r <= STRETCH;
            cnt_r   <= STRETCH_LOAD;
          end
        end
        STRETCH: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            aresetn_out_r[0] <= 1'b1;
            if (NUM_OUT == 1) begin
              state_r      <= DONE;
              reset_done_r <= 1'b1;
              busy_r       <= 1'b0;
            end else begin
              state_r <= RELEASE;
              cnt_r   <= STEP_LOAD;
              idx_r   <= IDX_W'(1);
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            // Loop form keeps the write in range for non power-of-two NUM_OUT.
            for (int i = 0; i < NUM_OUT; i++) begin
              if (IDX_W'(i) == idx_r) begin
                aresetn_out_r[i] <= 1'b1;
              end
            end
            if (idx_r == LAST_IDX) begin
              state_r      <= DONE;
              reset_done_r <= 1'b1;
              busy_r       <= 1'b0;
            end else begin
              idx_r <= idx_r + IDX_W'(1);
              cnt_r <= STEP_LOAD;
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        DONE: begin
          aresetn_out_r <= {NUM_OUT{1'b1}};
        end
        default: begin
          state_r <= ASSERT;
        end
      endcase
    end
  end

  assign aresetn_out = aresetn_out_r;
  assign reset_done  = reset_done_r;
  assign busy        = busy_r;

`ifdef ARESETN_SEQ_SOFT_CNT_EN
  logic        soft_prev_r;
  logic [15:0] soft_cnt_r;

  // Saturating count of accepted soft_reset rising edges; only aresetn_in clears it.
  always_ff @(posedge aclk or negedge aresetn_in) begin
    if (!aresetn_in) begin
      soft_prev_r <= 1'b0;
      soft_cnt_r  <= 16'h0000;
    end else begin
      soft_prev_r <= soft_reset;
      if (soft_req_s && !soft_prev_r && (soft_cnt_r != 16'hFFFF)) begin
        soft_cnt_r <= soft_cnt_r + 16'h0001;
      end
    end
  end

  assign soft_reset_count = soft_cnt_r;
`endif

endmodule

// File: doc/aresetn_seq.md
Name: aresetn_seq

Overview:
- Parametrised reset synchroniser and release sequencer for one clock domain (aclk).
- Asserts NUM_OUT active-low resets asynchronously. Synchronises deassertion through a configurable flop chain, stretches reset for a minimum time, then releases the outputs one by one at fixed intervals.
- Accepts a synchronous soft-reset request, so software can re-sequence the domain without touching aresetn_in.
- Sits between the board/PLL reset and the AXI subsystems of a clock domain (e.g. interconnect first, then DMA, then user cores).

Parameters:
- SYNC_STAGES, 2, synchroniser depth on aresetn_in deassertion; legal range >= 2.
- NUM_OUT, 3, number of sequenced reset outputs; legal range >= 1.
- STRETCH_CYCLES, 16, aclk cycles all outputs stay low after synchronised deassertion; legal range >= 1.
- STEP_CYCLES, 8, aclk cycles between consecutive output releases; legal range >= 1.

Ports:
- aclk, input, 1, clock.
- aresetn_in, input, 1, reset: asynchronous, active-low.
- soft_reset, input, 1, synchronous reset request, sampled on the aclk rising edge, level or pulse.
- aresetn_out, output, NUM_OUT, sequenced active-low resets; bit 0 is released first.
- reset_done, output, 1, high once every output is released.
- busy, output, 1, high while sequencing (states ASSERT, STRETCH, RELEASE).

Behaviour:
- Reset values: aresetn_in low drives the following asynchronously and immediately:
  - aresetn_out = 0, reset_done = 0, busy = 1.
  - Sync chain = 0, counters = 0, state = ASSERT.
- Synchroniser: SYNC_STAGES flops with ASYNC_REG. Async clear; shifts in 1. Output is sync_n.
- Edge numbering: edge 1 is the first aclk rising edge after aresetn_in rises. sync_n = 1 after edge SYNC_STAGES.
- FSM states and transitions:
  - ASSERT: all outputs low. Go to STRETCH when sync_n = 1; the state register takes STRETCH at edge SYNC_STAGES+1. On entry, cnt is loaded with STRETCH_CYCLES-1.
  - STRETCH: all outputs low; cnt decrements. When cnt == 0, set aresetn_out[0] = 1, load cnt = STEP_CYCLES-1, set idx = 1, and go to RELEASE. If NUM_OUT == 1, go to DONE instead.
  - RELEASE: cnt decrements. When cnt == 0, set aresetn_out[idx] = 1. If idx == NUM_OUT-1, go to DONE; otherwise idx++ and reload cnt.
  - DONE: all outputs high, reset_done = 1, busy = 0.
- Release timing with defaults:
  - aresetn_out[0] rises at edge SYNC_STAGES+1+STRETCH_CYCLES = 19.
  - Each further bit rises STEP_CYCLES edges later: bit 1 at edge 27, bit 2 at edge 35.
  - reset_done rises on the same edge as aresetn_out[NUM_OUT-1].
- Output rules:
  - Once released, a bit stays high until the next reset.
  - All outputs are registered; deassertion is always synchronous to aclk.
- soft_reset, sampled high in STRETCH, RELEASE or DONE:
  - Next edge: all aresetn_out = 0, reset_done = 0, busy = 1.
  - State becomes STRETCH with cnt reloaded; the full STRETCH/RELEASE sequence repeats from there.
  - Ignored in ASSERT.
  - Held high: the block stays in STRETCH with cnt reloading every cycle; release starts STRETCH_CYCLES edges after soft_reset falls.
- aresetn_in low mid-sequence: immediate async return to the reset values. The synchroniser restarts.
- aresetn_in and soft_reset active together: aresetn_in wins.
- cnt width is clog2(max(STRETCH_CYCLES, STEP_CYCLES)) with a minimum of 1. idx width is clog2(NUM_OUT) with a minimum of 1.

Optional Feature:
- Macro: ARESETN_SEQ_SOFT_CNT_EN.
- Defined:
  - Adds output soft_reset_count (16 bits), a saturating count of accepted soft_reset requests.
  - Counts rising edges of soft_reset only when the request is accepted, i.e. not in ASSERT.
  - Cleared only by aresetn_in.
  - Holds 16'hFFFF once reached.
- Undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Package aresetn_seq_pkg:
  - State encoding localparams: ASSERT = 2'd0, STRETCH = 2'd1, RELEASE = 2'd2, DONE = 2'd3.
  - clog2 width function.
- Sub-module aresetn_sync:
  - Parameter SYNC_STAGES.
  - Ports aclk, aresetn_in, sync_n.
  - Reusable elsewhere as a plain reset synchroniser.

Test Plan:
- Defaults; release aresetn_in and count edges -> aresetn_out goes 001 at edge 19, 011 at edge 27, 111 at edge 35; reset_done = 1 and busy = 0 at edge 35.
- Pull aresetn_in low for 1 ns mid-RELEASE, asynchronous to aclk -> outputs 000 with no clock edge; the sequence restarts from edge 1 after release.
- In DONE, pulse soft_reset for one cycle -> next edge outputs 000 and busy = 1; 001 appears 16 edges later, then 011 and 111 at 8-edge steps.
- Hold soft_reset high for 40 cycles -> outputs stay 000 throughout; 001 appears 16 edges after the fall.
- SYNC_STAGES = 3, NUM_OUT = 1, STRETCH_CYCLES = 1 -> aresetn_out[0] and reset_done rise together at edge 5.
- With ARESETN_SEQ_SOFT_CNT_EN defined: 3 soft_reset pulses after DONE, plus 1 pulse during ASSERT -> soft_reset_count = 3; a subsequent aresetn_in pulse -> 0.
